mul_result_collector: RTL and testbench

Output-side companion to the vectorized quantized multiply unit. It receives the multiplier's free-running result stream: MAX_VECTOR_SIZE int8 lanes qualified by a one-cycle valid, with no backpressure. It buffers the vectors in a small FIFO and re-emits them as a ready/valid stream with a byte-keep mask and end-of-tensor marker, so the write-back path can stall without losing results. It is programmed per tensor with an element count and signals completion and overflow to the controller.

---
 rtl/mul_result_collector_pkg.sv | 16 +
 rtl/npu_sync_fifo.sv | 60 ++++++
 rtl/mul_result_collector.sv | 138 +++++++++++++
 tb/tb_mul_result_collector.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_result_collector_pkg.sv
// Shared definitions for the multiply-unit result collector.
//   INT8_SIZE  : width of one result lane
//   INT32_SIZE : width of the per-tensor element count
//   state_e    : collector control states
package mul_result_collector_pkg;

  localparam int INT8_SIZE  = 8;
  localparam int INT32_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/npu_sync_fifo.sv
// Single-clock FIFO with simultaneous push/pop.
//   push/din   : write side; a push into a full FIFO is accepted only if a
//                pop happens in the same cycle
//   pop/dout   : read side; dout shows the head entry, zero when empty
//   full/empty : occupancy flags derived from a registered count
module npu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Zero when empty so the stream outputs sit at a clean value after reset.
  assign dout = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: storage has no reset; every entry is written before it can be read,
  // so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mul_result_collector.sv
// Collects the multiplier's free-running result vectors into a FIFO and
// re-emits them as a ready/valid stream with keep mask and tensor-last flag.
//   start/num_elements : begin a tensor of num_elements int8 results
//   valid_in/data_in   : multiplier result stream (no backpressure)
//   m_valid/m_ready    : output handshake; m_data/m_keep/m_last per beat
//   busy               : tensor in progress
//   done               : one-cycle completion pulse
//   overflow           : sticky, a vector was dropped on a full FIFO
module mul_result_collector
  import mul_result_collector_pkg::*;
#(
  parameter int MAX_VECTOR_SIZE = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [INT32_SIZE-1:0]                num_elements,
  input  logic                                 valid_in,
  input  logic [INT8_SIZE*MAX_VECTOR_SIZE-1:0] data_in,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [INT8_SIZE*MAX_VECTOR_SIZE-1:0] m_data,
  output logic [MAX_VECTOR_SIZE-1:0]           m_keep,
  output logic                                 m_last,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 overflow
);

  localparam int DW = INT8_SIZE * MAX_VECTOR_SIZE;
  localparam int FW = DW + MAX_VECTOR_SIZE + 1;

  state_e                 state_q, state_d;
  logic [INT32_SIZE-1:0]  remaining_q, remaining_d;
  logic                   overflow_q, overflow_d;
  logic                   last_lost_q, last_lost_d;
  logic                   done_q, done_d;

  logic [INT32_SIZE-1:0]      take;
  logic [MAX_VECTOR_SIZE-1:0] keep;
  logic                       is_last;
  logic                       push;
  logic                       pop_fire;
  logic                       fifo_full, fifo_empty;
  logic [FW-1:0]              fifo_dout;

  assign m_valid  = !fifo_empty;
  assign pop_fire = m_valid && m_ready;
  assign {m_data, m_keep, m_last} = fifo_dout;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = overflow_q;

  // Elements carried by the next vector and the matching lane mask.
  always_comb begin
    take    = (remaining_q < INT32_SIZE'(MAX_VECTOR_SIZE)) ? remaining_q
                                                           : INT32_SIZE'(MAX_VECTOR_SIZE);
    is_last = (remaining_q == take);
    for (int i = 0; i < MAX_VECTOR_SIZE; i++) keep[i] = (INT32_SIZE'(i) < take);
  end

  // NOTE: every signal gets its default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    overflow_d  = overflow_q;
    last_lost_d = last_lost_q;
    done_d      = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_elements != '0) begin
            state_d     = RUN;
            remaining_d = num_elements;
            overflow_d  = 1'b0;
            last_lost_d = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (valid_in) begin
          push        = 1'b1;
          remaining_d = remaining_q - take;
          if (fifo_full && !pop_fire) begin
            overflow_d = 1'b1;
            if (is_last) last_lost_d = 1'b1;
          end
          if (is_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // A dropped last vector can never be handshaken, so finish once the
        // surviving entries have drained instead of waiting forever.
        if ((pop_fire && m_last) || (last_lost_q && fifo_empty)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      overflow_q  <= 1'b0;
      last_lost_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      overflow_q  <= overflow_d;
      last_lost_q <= last_lost_d;
      done_q      <= done_d;
    end
  end

  npu_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({data_in, keep, is_last}),
    .pop   (pop_fire),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_mul_result_collector.sv
module tb_mul_result_collector;

  localparam int MVS = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] num_elements = '0;
  logic        valid_in = 1'b0;
  logic [63:0] data_in = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic        m_last;
  logic        busy;
  logic        done;
  logic        overflow;

  always #5 clk = ~clk;

  mul_result_collector #(
    .MAX_VECTOR_SIZE (MVS),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_elements (num_elements),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_keep       (m_keep),
    .m_last       (m_last),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t       sb[$];
  beat_t       exp_beat;
  int unsigned model_rem;
  int          vectors = 0;
  int          miscompares = 0;
  int          beat_cnt = 0;
  int          done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output monitor: stalled head must equal the oldest expected beat; a
  // handshake pops and compares it.
  always @(negedge clk) begin
    if (rst) begin
      if (done) done_cnt++;
      if (m_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", {63'd0, m_valid}, 64'd0);
        end else if (m_ready) begin
          exp_beat = sb.pop_front();
          beat_cnt++;
          check("beat_data", m_data, exp_beat.data);
          check("beat_keep", {56'd0, m_keep}, {56'd0, exp_beat.keep});
          check("beat_last", {63'd0, m_last}, {63'd0, exp_beat.last});
        end else begin
          check("stall_data", m_data, sb[0].data);
          check("stall_last", {63'd0, m_last}, {63'd0, sb[0].last});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int unsigned n);
    start = 1'b1;
    num_elements = n;
    model_rem = n;
    tick();
    start = 1'b0;
  endtask

  // Drive one result vector; the model decides keep/last and whether the
  // collector should keep it.
  task automatic send(input logic [63:0] d, input bit drop);
    int unsigned n;
    beat_t b;
    n = (model_rem < MVS) ? model_rem : MVS;
    b.data = d;
    b.keep = 8'((16'd1 << n) - 16'd1);
    b.last = (model_rem == n);
    model_rem = model_rem - n;
    if (!drop) sb.push_back(b);
    valid_in = 1'b1;
    data_in = d;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic send_ignored(input logic [63:0] d);
    valid_in = 1'b1;
    data_in = d;
    tick();
    valid_in = 1'b0;
  endtask

  function automatic logic [63:0] vec(input int k);
    return {8{8'(k)}} ^ 64'h0011_2233_4455_6677;
  endfunction

  int b0, d0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_m_keep", {56'd0, m_keep}, 64'd0);
    check("rst_m_last", {63'd0, m_last}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    rst = 1'b1;
    tick();

    // 16 elements, two back-to-back vectors, downstream always ready
    m_ready = 1'b1;
    check("t1_busy_before", {63'd0, busy}, 64'd0);
    do_start(16);
    check("t1_busy_after", {63'd0, busy}, 64'd1);
    send(vec(1), 0);
    check("t1_latency", {63'd0, m_valid}, 64'd1);
    send(vec(2), 0);
    tick();
    check("t1_done", {63'd0, done}, 64'd1);
    check("t1_busy_fall", {63'd0, busy}, 64'd0);
    tick();
    check("t1_done_width", {63'd0, done}, 64'd0);
    check("t1_sb_empty", 64'(sb.size()), 64'd0);

    // 13 elements: partial last vector, extra valid ignored in DRAIN
    do_start(13);
    send(vec(3), 0);
    send(vec(4), 0);
    send_ignored(vec(5));
    check("t2_done", {63'd0, done}, 64'd1);
    send_ignored(vec(6));
    tick();
    check("t2_no_beat", {63'd0, m_valid}, 64'd0);
    check("t2_sb_empty", 64'(sb.size()), 64'd0);

    // Overflow: five vectors into a stalled depth-4 FIFO
    m_ready = 1'b0;
    do_start(48);
    for (int k = 0; k < 4; k++) send(vec(10 + k), 0);
    check("t3_no_ovf_yet", {63'd0, overflow}, 64'd0);
    send(vec(14), 1);
    check("t3_overflow", {63'd0, overflow}, 64'd1);
    tick();
    tick();
    check("t3_stall_head", m_data, vec(10));
    m_ready = 1'b1;
    b0 = beat_cnt;
    for (int k = 0; k < 4; k++) tick();
    check("t3_beats", 64'(beat_cnt - b0), 64'd4);
    check("t3_empty", {63'd0, m_valid}, 64'd0);
    send(vec(15), 0);
    tick();
    check("t3_done", {63'd0, done}, 64'd1);
    check("t3_ovf_sticky", {63'd0, overflow}, 64'd1);

    // Full FIFO with simultaneous push and pop
    m_ready = 1'b0;
    do_start(48);
    check("t4_ovf_cleared", {63'd0, overflow}, 64'd0);
    for (int k = 0; k < 4; k++) send(vec(20 + k), 0);
    m_ready = 1'b1;
    send(vec(24), 0);
    m_ready = 1'b0;
    check("t4_no_overflow", {63'd0, overflow}, 64'd0);
    tick();
    check("t4_stall_head", m_data, vec(21));
    b0 = beat_cnt;
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("t4_occupancy", 64'(beat_cnt - b0), 64'd4);
    check("t4_empty", {63'd0, m_valid}, 64'd0);
    send(vec(25), 0);
    tick();
    check("t4_done", {63'd0, done}, 64'd1);

    // Zero-length tensor
    tick();
    d0 = done_cnt;
    do_start(0);
    check("t5_done", {63'd0, done}, 64'd1);
    check("t5_busy", {63'd0, busy}, 64'd0);
    check("t5_m_valid", {63'd0, m_valid}, 64'd0);
    tick();
    check("t5_done_width", {63'd0, done}, 64'd0);
    check("t5_busy2", {63'd0, busy}, 64'd0);
    check("t5_done_count", 64'(done_cnt - d0), 64'd1);

    // Asynchronous reset mid-RUN with three entries queued
    m_ready = 1'b0;
    do_start(40);
    for (int k = 0; k < 3; k++) send(vec(30 + k), 0);
    check("t6_queued", {63'd0, m_valid}, 64'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_m_valid", {63'd0, m_valid}, 64'd0);
    check("t6_m_data", m_data, 64'd0);
    check("t6_m_keep", {56'd0, m_keep}, 64'd0);
    check("t6_m_last", {63'd0, m_last}, 64'd0);
    check("t6_busy", {63'd0, busy}, 64'd0);
    check("t6_done", {63'd0, done}, 64'd0);
    sb.delete();
    tick();
    rst = 1'b1;
    tick();
    m_ready = 1'b1;
    do_start(8);
    send(vec(40), 0);
    check("t6_restart_valid", {63'd0, m_valid}, 64'd1);
    tick();
    check("t6_restart_done", {63'd0, done}, 64'd1);
    tick();
    check("t6_sb_empty", 64'(sb.size()), 64'd0);
    check("t6_final_idle", {63'd0, m_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
